// File: rtl/exec_divx.sv
// Multi-cycle integer divider: restoring shift-subtract, one quotient bit per cycle,
// signed/unsigned, quotient or remainder select, flags in the adder's {V,N,Z,C} layout.
module exec_divx #(
   parameter int W_OPR   = 32,
   parameter int W_FLAGS = 4
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic [W_OPR-1:0]   opr0_i,
   input  logic [W_OPR-1:0]   opr1_i,
   input  logic [1:0]         select_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [W_OPR-1:0]   result_o,
   output logic [W_FLAGS-1:0] flags_o
);

   localparam int CW = $clog2(W_OPR);
   localparam logic [W_OPR-1:0] MIN_NEG = {1'b1, {(W_OPR-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [W_OPR-1:0]   a_q, a_d;        // dividend, becomes quotient as bits shift in
   logic [W_OPR-1:0]   b_q, b_d;        // divisor (magnitude after PREP)
   logic [W_OPR-1:0]   rem_q, rem_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         sel_q, sel_d;
   logic               qneg_q, qneg_d, rneg_q, rneg_d, ovf_q, ovf_d;
   logic [W_OPR-1:0]   result_q, result_d;
   logic [W_FLAGS-1:0] flags_q, flags_d;

   logic [W_OPR:0]     shifted, trial;
   logic [W_OPR-1:0]   q_fix, r_fix, res_fix, res_dz;

   function automatic logic [W_FLAGS-1:0] mk_flags(input logic [W_OPR-1:0] res,
                                                   input logic ovf, input logic cry);
      logic [W_FLAGS-1:0] f;
      f    = '0;
      f[3] = ovf;
      f[2] = res[W_OPR-1];
      f[1] = ~|res;
      f[0] = cry;
      return f;
   endfunction

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      flags_d  = flags_q;

      // Trial subtract is one bit wider so its MSB is the borrow.
      shifted = {rem_q, a_q[W_OPR-1]};
      trial   = shifted - {1'b0, b_q};
      q_fix   = qneg_q ? -a_q : a_q;
      r_fix   = rneg_q ? -rem_q : rem_q;
      res_fix = sel_q[1] ? r_fix : q_fix;
      res_dz  = sel_q[1] ? a_q : '1;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               a_d     = opr0_i;
               b_d     = opr1_i;
               sel_d   = select_i;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            rem_d  = '0;
            cnt_d  = '0;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
            ovf_d  = 1'b0;
            if (b_q == '0) begin
               result_d = res_dz;
               flags_d  = mk_flags(res_dz, 1'b0, 1'b1);
               state_d  = S_DONE;
            end else begin
               if (sel_q[0]) begin
                  a_d    = a_q[W_OPR-1] ? -a_q : a_q;
                  b_d    = b_q[W_OPR-1] ? -b_q : b_q;
                  qneg_d = a_q[W_OPR-1] ^ b_q[W_OPR-1];
                  rneg_d = a_q[W_OPR-1];
                  // MIN/-1 wraps naturally; only the quotient reports it.
                  ovf_d  = (a_q == MIN_NEG) && (&b_q) && !sel_q[1];
               end
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            rem_d = trial[W_OPR] ? shifted[W_OPR-1:0] : trial[W_OPR-1:0];
            a_d   = {a_q[W_OPR-2:0], ~trial[W_OPR]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W_OPR-1)) state_d = S_FIX;
         end
         S_FIX: begin
            result_d = res_fix;
            flags_d  = mk_flags(res_fix, ovf_q, 1'b0);
            state_d  = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         sel_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign busy_o   = (state_q != S_IDLE);
   assign done_o   = (state_q == S_DONE);
   assign result_o = result_q;
   assign flags_o  = flags_q;

endmodule

// File: tb/tb_exec_divx.sv
// Directed and randomized checks of exec_divx against an arithmetic reference model.
module tb_exec_divx;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] opr0_i = '0;
   logic [31:0] opr1_i = '0;
   logic [1:0]  select_i = '0;
   logic        busy_o, done_o;
   logic [31:0] result_o;
   logic [3:0]  flags_o;

   int ncmp = 0;
   int nfail = 0;

   exec_divx #(.W_OPR(32), .W_FLAGS(4)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
      .opr0_i(opr0_i), .opr1_i(opr1_i), .select_i(select_i),
      .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .flags_o(flags_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain language-level division, with the divide-by-zero and MIN/-1 rules.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                        output logic [31:0] r, output logic [3:0] f);
      logic [31:0] q, rm;
      logic        ovf;
      ovf = 1'b0;
      if (b == 0) begin
         q = '1; rm = a;
      end else if (sel[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; rm = 0; ovf = 1'b1;
         end else begin
            q  = $signed(a) / $signed(b);
            rm = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b; rm = a % b;
      end
      r = sel[1] ? rm : q;
      f = {ovf & ~sel[1], r[31], r == 0, b == 0};
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 15));
         5: return -32'($urandom_range(1, 15));
         default: return $urandom();
      endcase
   endfunction

   // One operation; inj>0 pulses start_i with other operands at that cycle count.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                        input logic [31:0] er, input logic [3:0] ef, input int elat,
                        input int inj);
      logic [31:0] prev;
      int n;
      @(negedge clk_i);
      opr0_i = a; opr1_i = b; select_i = sel; start_i = 1'b1;
      prev = result_o;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      opr0_i = $urandom(); opr1_i = $urandom(); select_i = 2'($urandom());
      n = 1;
      while (done_o !== 1'b1 && n < 100) begin
         chk("busy_run", busy_o, 1);
         chk("hold_run", result_o, prev);
         start_i = (n == inj);
         if (n == inj) begin opr0_i = $urandom(); opr1_i = $urandom(); end
         @(posedge clk_i); #1;
         n++;
      end
      chk("latency", n, elat);
      chk("busy_done", busy_o, 1);
      chk("result", result_o, er);
      chk("flags", flags_o, ef);
      start_i = (n == inj);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      chk("done_width", done_o, 0);
      chk("idle_after", busy_o, 0);
      chk("result_held", result_o, er);
   endtask

   initial begin
      logic [31:0] a, b, er;
      logic [1:0]  sel;
      logic [3:0]  ef;

      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_flags", flags_o, 0);
      repeat (2) @(posedge clk_i);
      #1 rst_n_i = 1'b1;

      do_op(32'd100, 32'd7, 2'b00, 32'd14, 4'b0000, 35, 0);
      do_op(32'd100, 32'd7, 2'b10, 32'd2, 4'b0000, 35, 0);
      do_op(-32'd7, 32'd2, 2'b01, 32'hFFFF_FFFD, 4'b0100, 35, 0);
      do_op(-32'd7, 32'd2, 2'b11, 32'hFFFF_FFFF, 4'b0100, 35, 0);
      do_op(32'd5, 32'd0, 2'b00, 32'hFFFF_FFFF, 4'b0101, 2, 0);
      do_op(32'd5, 32'd0, 2'b10, 32'd5, 4'b0001, 2, 0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 32'h8000_0000, 4'b1100, 35, 0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'h0, 4'b0010, 35, 0);

      // start_i during RUN, then during DONE: both must be ignored
      do_op(32'd100, 32'd7, 2'b00, 32'd14, 4'b0000, 35, 10);
      do_op(32'd1000, 32'd3, 2'b10, 32'd1, 4'b0000, 35, 35);

      // reset mid-RUN
      @(negedge clk_i);
      opr0_i = 32'd1000; opr1_i = 32'd3; select_i = 2'b00; start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1 rst_n_i = 1'b0;
      #1;
      chk("abort_busy", busy_o, 0);
      chk("abort_done", done_o, 0);
      chk("abort_result", result_o, 0);
      chk("abort_flags", flags_o, 0);
      repeat (2) @(posedge clk_i);
      #1 rst_n_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i); #1;
         chk("post_abort_quiet", {busy_o, done_o, result_o}, 0);
      end
      do_op(32'd1000, 32'd3, 2'b00, 32'd333, 4'b0000, 35, 0);

      for (int i = 0; i < 1200; i++) begin
         a   = pick();
         b   = pick();
         sel = 2'($urandom());
         model(a, b, sel, er, ef);
         do_op(a, b, sel, er, ef, (b == 0) ? 2 : 35, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
